// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and exception flagging.
// Define PIPE_STAGE_PERF_EN to add the transfer and stall performance counters.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 9,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [EXC_W-1:0]  up_exc,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [EXC_W-1:0]  dn_exc,
    output logic              dn_has_exc,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  perf_xfer_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt,
`endif
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [EXC_W-1:0]  main_exc_q, main_exc_d;
    logic [EXC_W-1:0]  skid_exc_q, skid_exc_d;
    logic              up_ready_q, up_ready_d;
    logic [EXC_W-1:0]  dn_exc_q, dn_exc_d;
    logic              has_exc_q, has_exc_d;
    logic [1:0]        occ_q, occ_d;
    logic              up_xfer_s;
    logic              dn_xfer_s;

    assign up_xfer_s = up_valid & up_ready_q;
    assign dn_xfer_s = main_valid_q & dn_ready;

    // Next-state for both slots, keyed on (main_valid, skid_valid).
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        main_exc_d   = main_exc_q;
        skid_data_d  = skid_data_q;
        skid_exc_d   = skid_exc_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (up_xfer_s) begin
                        main_valid_d = 1'b1;
                        main_data_d  = up_data;
                        main_exc_d   = up_exc;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (up_xfer_s && !dn_xfer_s) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = up_data;
                        skid_exc_d   = up_exc;
                    end else if (up_xfer_s && dn_xfer_s) begin
                        main_data_d = up_data;
                        main_exc_d  = up_exc;
                    end else if (dn_xfer_s) begin
                        main_valid_d = 1'b0;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // Skid is always the younger entry, so it moves into main.
                    if (dn_xfer_s) begin
                        main_data_d  = skid_data_q;
                        main_exc_d   = skid_exc_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Output-side flops are computed from next state so every output comes straight from a flop.
    always_comb begin
        up_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        if (main_valid_d) begin
            dn_exc_d  = main_exc_d;
            has_exc_d = |main_exc_d;
        end else begin
            dn_exc_d  = {EXC_W{1'b0}};
            has_exc_d = 1'b0;
        end
    end

    // Control/status state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            up_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
            dn_exc_q     <= {EXC_W{1'b0}};
            has_exc_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            up_ready_q   <= up_ready_d;
            occ_q        <= occ_d;
            dn_exc_q     <= dn_exc_d;
            has_exc_q    <= has_exc_d;
        end
    end

    // Payload flops are never cleared; validity alone qualifies them.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        main_exc_q  <= main_exc_d;
        skid_data_q <= skid_data_d;
        skid_exc_q  <= skid_exc_d;
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] xfer_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Performance counters wrap naturally and ignore flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q  <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (dn_xfer_s) begin
                xfer_cnt_q <= xfer_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                xfer_cnt_q <= xfer_cnt_q;
            end
            if (main_valid_q && !dn_ready) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign perf_xfer_cnt  = xfer_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

    assign up_ready   = up_ready_q;
    assign dn_valid   = main_valid_q;
    assign dn_data    = main_data_q;
    assign dn_exc     = dn_exc_q;
    assign dn_has_exc = has_exc_q;
    assign occupancy  = occ_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised successor to the fixed ID_EXE / EXE_MEM / MEM_WB pipeline registers.
- Carries an arbitrary payload plus an exception vector between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer registers the upstream ready, so downstream backpressure never forms a combinational ready chain across stages.
- Supports stage flush, holds entry order, and flags outgoing entries that carry exceptions.

Parameters:
DATA_W, 64, payload width in bits (bus, PC+1, control fields packed by caller)
EXC_W, 9, exception vector width (matches ExceptinPipeType)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
up_valid  in  1  upstream entry present
up_ready  out  1  stage can accept an entry this cycle
up_data  in  DATA_W  upstream payload
up_exc  in  EXC_W  upstream exception vector
dn_valid  out  1  entry presented downstream
dn_ready  in  1  downstream accepts this cycle
dn_data  out  DATA_W  downstream payload
dn_exc  out  EXC_W  downstream exception vector, zero when dn_valid=0
dn_has_exc  out  1  dn_valid & (|dn_exc)
flush  in  1  discard all held entries and any entry offered this cycle
occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Storage: main slot (drives dn_*) and skid slot. Each slot has a payload, an exception vector and a valid bit.
- Handshakes:
  - Upstream transfer = up_valid & up_ready.
  - Downstream transfer = dn_valid & dn_ready.
  - up_ready = ~skid_valid, taken from a flop. It never depends combinationally on dn_ready.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0):
    - up transfer -> BUSY; main loads up_*.
  - BUSY (1,0):
    - up transfer, no dn transfer -> FULL; skid loads up_*.
    - up transfer and dn transfer -> BUSY; main loads up_*.
    - dn transfer only -> EMPTY.
    - neither -> hold.
  - FULL (1,1):
    - up_ready=0, so no up transfer is possible.
    - dn transfer -> BUSY; main loads skid, skid_valid clears.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Latency and throughput: 1 cycle from up transfer to dn_valid when EMPTY. Sustained throughput is 1 entry/cycle when dn_ready is held high.
- dn_valid holds: once asserted, dn_data and dn_exc stay stable until a dn transfer or flush.
- flush (highest priority below rst):
  - Both valid bits clear at the next edge. An up_* offered in the same cycle is dropped.
  - A dn transfer in the flush cycle still counts as completed for the consumer.
  - The next cycle is EMPTY with up_ready=1.
  - Payload flops are not cleared; dn_exc reads 0 because of valid gating.
- rst:
  - Same clearing as flush, plus all counters go to 0.
  - Reset values: dn_valid=0, up_ready=1, dn_exc=0, dn_has_exc=0, occupancy=0. dn_data is don't-care but must be driven from flops.
- rst or flush in the middle of a FULL backpressure run: both entries are discarded, no partial state remains.
- occupancy = main_valid + skid_valid, registered alongside the valid bits.
- Exceptions are carried, not acted on. The stage never suppresses or reorders an entry because it has an exception.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_xfer_cnt[CNT_W] and perf_stall_cnt[CNT_W].
  - perf_xfer_cnt increments on each dn transfer.
  - perf_stall_cnt increments on each cycle with dn_valid & ~dn_ready.
  - Both counters wrap modulo 2^CNT_W, clear on rst, and are not affected by flush.
- Undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Streaming: rst then up_valid=1 and dn_ready=1 constantly, data 0x1,0x2,0x3 -> dn_data 0x1,0x2,0x3 on consecutive cycles starting 1 cycle later; occupancy stays 1; up_ready stays 1.
- Backpressure: dn_ready=0 while offering 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy=2, up_ready=0, 0xC held upstream. Release dn_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush when FULL: hold 0x10/0x11, assert flush with up_valid offering 0x12 -> next cycle dn_valid=0, occupancy=0, up_ready=1; 0x12 never appears downstream.
- Exception flag: offer up_exc=9'h008 with 0x55 -> dn_has_exc=1 and dn_exc=9'h008 while dn_valid. After it drains -> dn_exc=0 and dn_has_exc=0.
- Reset mid-run: rst asserted while FULL -> next edge outputs match reset values; the first subsequent up_valid is accepted immediately.
- PIPE_STAGE_PERF_EN: 3 stall cycles then 4 transfers -> perf_stall_cnt=3, perf_xfer_cnt=4. Counter preset to 2^CNT_W-1 plus one transfer -> wraps to 0.
